// File: rtl/enc_16to4.sv
// Registered priority encoder: reports the index of the highest asserted
// request line, whether any line is set, and whether more than one is set.
module enc_16to4 #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in,
   input  logic             en,
   output logic [OUT_W-1:0] out,
   output logic             valid,
   output logic             multi
);

   // Scan upward so the last hit, i.e. the highest set bit, wins.
   function automatic logic [OUT_W-1:0] msb_index(input logic [IN_W-1:0] v);
      logic [OUT_W-1:0] idx;
      idx = {OUT_W{1'b0}};
      for (int i = 0; i < IN_W; i++) begin
         if (v[i]) begin
            idx = OUT_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Clearing the lowest set bit leaves something only if two or more were set.
   function automatic logic has_multiple(input logic [IN_W-1:0] v);
      return ((v & (v - {{(IN_W-1){1'b0}}, 1'b1})) != {IN_W{1'b0}});
   endfunction

   logic [OUT_W-1:0] out_s;
   logic             valid_s;
   logic             multi_s;
   logic [OUT_W-1:0] out_r;
   logic             valid_r;
   logic             multi_r;

   // Next-state encode; a disabled encoder presents the idle pattern.
   always_comb begin
      out_s   = {OUT_W{1'b0}};
      valid_s = 1'b0;
      multi_s = 1'b0;
      if (en) begin
         out_s   = msb_index(in);
         valid_s = (in != {IN_W{1'b0}});
         multi_s = has_multiple(in);
      end else begin
         out_s   = {OUT_W{1'b0}};
         valid_s = 1'b0;
         multi_s = 1'b0;
      end
   end

   // Output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_r   <= {OUT_W{1'b0}};
         valid_r <= 1'b0;
         multi_r <= 1'b0;
      end else begin
         out_r   <= out_s;
         valid_r <= valid_s;
         multi_r <= multi_s;
      end
   end

   assign out   = out_r;
   assign valid = valid_r;
   assign multi = multi_r;

endmodule

// File: tb/tb_enc_16to4.sv
// Scoreboard bench for enc_16to4: the driver queues the expected registered
// response for each cycle and a monitor pops and compares after every edge.
module tb_enc_16to4;

   typedef struct {
      logic [3:0] o;
      logic       v;
      logic       m;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_v;
   logic        en;
   logic [3:0]  out;
   logic        valid;
   logic        multi;

   exp_t exp_q[$];
   exp_t last_exp;
   logic have_last;
   int   n_checks;
   int   n_pass;

   enc_16to4 #(.IN_W(16), .OUT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in_v),
      .en    (en),
      .out   (out),
      .valid (valid),
      .multi (multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: floor(log2(v)) via $clog2, popcount for multi.
   function automatic exp_t model(input logic r, input logic e, input logic [15:0] v);
      exp_t x;
      int   iv;
      iv = int'(v);
      if (!r || !e || iv == 0) begin
         x.o = 4'd0;
         x.v = 1'b0;
         x.m = 1'b0;
      end else begin
         x.o = 4'($clog2(iv + 1) - 1);
         x.v = 1'b1;
         x.m = ($countones(v) >= 2);
      end
      return x;
   endfunction

   task automatic step(input logic r, input logic e, input logic [15:0] v);
      @(negedge clk);
      rst_n = r;
      en    = e;
      in_v  = v;
      exp_q.push_back(model(r, e, v));
   endtask

   task automatic compare(input string name, input exp_t x);
      n_checks++;
      if (out === x.o && valid === x.v && multi === x.m) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got out=%0d valid=%0b multi=%0b, expected out=%0d valid=%0b multi=%0b",
                  name, $time, out, valid, multi, x.o, x.v, x.m);
      end
   endtask

   // Monitor: one expected response per edge, sampled just after it.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         last_exp  = exp_q.pop_front();
         have_last = 1'b1;
         compare("edge", last_exp);
      end
   end

   // Outputs must hold between edges.
   always @(negedge clk) begin
      if (have_last) begin
         compare("hold", last_exp);
      end
   end

   initial begin
      logic [15:0] v;
      logic        e;
      logic        r;
      int          kind;
      int          guard;
      n_checks  = 0;
      n_pass    = 0;
      have_last = 1'b0;
      rst_n     = 1'b0;
      en        = 1'b0;
      in_v      = 16'h0000;

      // Reset for two cycles, then walking one
      step(1'b0, 1'b1, 16'h0001);
      step(1'b0, 1'b1, 16'h0001);
      for (int k = 0; k < 16; k++) begin
         v = 16'h0001 << k;
         step(1'b1, 1'b1, v);
      end

      // Zero input then bit 0
      step(1'b1, 1'b1, 16'h0000);
      step(1'b1, 1'b1, 16'h0001);

      // Priority / multi-hot
      step(1'b1, 1'b1, 16'h8001);
      step(1'b1, 1'b1, 16'h0028);
      step(1'b1, 1'b1, 16'hFFFF);

      // Enable gating
      step(1'b1, 1'b0, 16'h0400);
      step(1'b1, 1'b1, 16'h0400);

      // Reset mid-operation
      step(1'b1, 1'b1, 16'h4000);
      step(1'b0, 1'b1, 16'h4000);
      step(1'b1, 1'b1, 16'h4000);

      // Back-to-back changes
      step(1'b1, 1'b1, 16'h0002);
      step(1'b1, 1'b1, 16'h0100);
      step(1'b1, 1'b1, 16'h0010);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0:       v = 16'h0001 << $urandom_range(0, 15);
            1:       v = 16'h0000;
            2:       v = 16'($urandom());
            default: v = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         endcase
         e = ($urandom_range(0, 7) != 0);
         r = ($urandom_range(0, 19) != 0);
         step(r, e, v);
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
